// File: rtl/dc_16to32.sv
// Halfword-to-word packer: pairs 16-bit beats into 32-bit words through a hold
// register and a 2-entry output FIFO. It flushes orphaned halfwords and pulses an error when it does.
module dc_16to32 #(
  parameter logic [15:0] PAD_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data_i,
  input  logic        s_sof,
  input  logic        s_eof,
  input  logic        s_vld_i,
  output logic        s_rdy_o,
  output logic [31:0] m_data_o,
  output logic [1:0]  m_keep_o,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_vld_o,
  input  logic        m_rdy_i,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {EMPTY, HALF, TAIL} state_t;

  state_t      state_reg, state_next;
  logic [15:0] lo_reg, lo_next;
  logic        lo_sof_reg, lo_sof_next;

  // FIFO entry layout: {data[31:0], keep[1:0], sof, eof}
  logic [35:0] entry_reg [2];
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [35:0] head;

  logic        accept, pop, push, flush;
  logic [35:0] push_word;
  logic        err_reg;
  logic [7:0]  err_cnt_reg;

  // Ready depends only on registered state and rst, never on m_rdy_i.
  assign s_rdy_o = !rst && (count_reg != 2'd2) && (state_reg != TAIL);
  assign accept  = s_vld_i && s_rdy_o;

  assign m_vld_o  = !rst && (count_reg != 2'd0);
  assign pop      = m_vld_o && m_rdy_i;
  assign head     = entry_reg[rd_ptr_reg];
  assign m_data_o = m_vld_o ? head[35:4] : 32'h0;
  assign m_keep_o = m_vld_o ? head[3:2]  : 2'b00;
  assign m_sof    = m_vld_o ? head[1]    : 1'b0;
  assign m_eof    = m_vld_o ? head[0]    : 1'b0;

  assign err_o     = err_reg;
  assign err_cnt_o = err_cnt_reg;

  always_comb begin
    state_next  = state_reg;
    lo_next     = lo_reg;
    lo_sof_next = lo_sof_reg;
    push        = 1'b0;
    push_word   = 36'h0;
    flush       = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          if (s_eof) begin
            push      = 1'b1;
            push_word = {PAD_VAL, s_data_i, 2'b01, s_sof, 1'b1};
          end else begin
            lo_next     = s_data_i;
            lo_sof_next = s_sof;
            state_next  = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          if (!s_sof) begin
            push       = 1'b1;
            push_word  = {s_data_i, lo_reg, 2'b11, lo_sof_reg, s_eof};
            state_next = EMPTY;
          end else begin
            // A new frame started before this one closed: emit the lone halfword.
            push        = 1'b1;
            push_word   = {PAD_VAL, lo_reg, 2'b01, lo_sof_reg, 1'b1};
            flush       = 1'b1;
            lo_next     = s_data_i;
            lo_sof_next = 1'b1;
            state_next  = s_eof ? TAIL : HALF;
          end
        end
      end
      TAIL: begin
        if (count_reg != 2'd2) begin
          push       = 1'b1;
          push_word  = {PAD_VAL, lo_reg, 2'b01, 1'b1, 1'b1};
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= EMPTY;
      lo_reg      <= 16'h0;
      lo_sof_reg  <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'h0;
    end else begin
      state_reg  <= state_next;
      lo_reg     <= lo_next;
      lo_sof_reg <= lo_sof_next;
      err_reg    <= flush;
      if (flush && err_cnt_reg != 8'hFF)
        err_cnt_reg <= err_cnt_reg + 8'd1;
      if (push)
        wr_ptr_reg <= !wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= !rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst)
          entry_reg[gi] <= 36'h0;
        else if (push && (wr_ptr_reg == 1'(gi)))
          entry_reg[gi] <= push_word;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dc_16to32.sv
// Directed bench for dc_16to32: popped words are collected at the negative edge
// and compared against hand-computed {data, keep, sof, eof} values.
module tb_dc_16to32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data_i = 16'h0;
  logic        s_sof = 1'b0;
  logic        s_eof = 1'b0;
  logic        s_vld_i = 1'b0;
  logic        s_rdy_o;
  logic [31:0] m_data_o;
  logic [1:0]  m_keep_o;
  logic        m_sof, m_eof, m_vld_o;
  logic        m_rdy_i = 1'b1;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int vectors = 0;
  int fails   = 0;
  int stalls  = 0;
  int err_pulses = 0;
  logic [35:0] q[$];

  dc_16to32 dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_sof(s_sof), .s_eof(s_eof), .s_vld_i(s_vld_i), .s_rdy_o(s_rdy_o),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_sof(m_sof), .m_eof(m_eof),
    .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // Sink: a word is consumed at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (m_vld_o && m_rdy_i)
      q.push_back({m_data_o, m_keep_o, m_sof, m_eof});
    if (err_o)
      err_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [35:0] exp);
    logic [63:0] obs;
    obs = (idx < q.size()) ? {28'h0, q[idx]} : 64'hDEAD_DEAD_DEAD_DEAD;
    chk(tag, obs, {28'h0, exp});
  endtask

  task automatic put(input logic [15:0] d, input logic sof, input logic eof);
    int waits;
    s_data_i = d; s_sof = sof; s_eof = eof; s_vld_i = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!s_rdy_o && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    stalls += waits;
    if (!s_rdy_o)
      chk("accept_timeout", {63'h0, s_rdy_o}, 64'h1);
    @(posedge clk); #1;
    s_vld_i = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state
    cycles(3);
    chk("rst_s_rdy", {63'h0, s_rdy_o}, 64'h0);
    chk("rst_m_vld", {63'h0, m_vld_o}, 64'h0);
    chk("rst_outs", {28'h0, m_data_o, m_keep_o, m_sof, m_eof}, 64'h0);
    chk("rst_err", {55'h0, err_o, err_cnt_o}, 64'h0);
    rst = 1'b0;
    cycles(1);
    chk("idle_s_rdy", {63'h0, s_rdy_o}, 64'h1);

    // Even frame at full rate
    q.delete(); stalls = 0; err_pulses = 0;
    put(16'h1111, 1, 0); put(16'h2222, 0, 0); put(16'h3333, 0, 0); put(16'h4444, 0, 1);
    chk("even_stalls", stalls, 0);
    cycles(3);
    chk("even_n", q.size(), 2);
    chk_word("even_w0", 0, {32'h22221111, 2'b11, 1'b1, 1'b0});
    chk_word("even_w1", 1, {32'h44443333, 2'b11, 1'b0, 1'b1});
    chk("idle_keep", {61'h0, m_keep_o, m_sof, m_eof}, 64'h0);

    // Odd frame: padded tail, no error
    q.delete(); err_pulses = 0;
    put(16'hAAAA, 1, 0); put(16'hBBBB, 0, 0); put(16'hCCCC, 0, 1);
    cycles(3);
    chk("odd_n", q.size(), 2);
    chk_word("odd_w0", 0, {32'hBBBBAAAA, 2'b11, 1'b1, 1'b0});
    chk_word("odd_w1", 1, {32'h0000CCCC, 2'b01, 1'b0, 1'b1});
    chk("odd_err", err_pulses, 0);

    // Orphan flush
    q.delete(); err_pulses = 0;
    put(16'h1111, 1, 0); put(16'h2222, 1, 0); put(16'h3333, 0, 1);
    cycles(3);
    chk("orph_n", q.size(), 2);
    chk_word("orph_w0", 0, {32'h00001111, 2'b01, 1'b1, 1'b1});
    chk_word("orph_w1", 1, {32'h33332222, 2'b11, 1'b1, 1'b1});
    chk("orph_pulses", err_pulses, 1);
    chk("orph_cnt", err_cnt_o, 8'd1);

    // Orphan followed by single-beat frame: TAIL blocks input for one cycle
    q.delete(); err_pulses = 0;
    put(16'h5555, 1, 0); put(16'h6666, 1, 1);
    chk("tail_rdy0", {63'h0, s_rdy_o}, 64'h0);
    cycles(1);
    chk("tail_rdy1", {63'h0, s_rdy_o}, 64'h1);
    cycles(3);
    chk("tail_n", q.size(), 2);
    chk_word("tail_w0", 0, {32'h00005555, 2'b01, 1'b1, 1'b1});
    chk_word("tail_w1", 1, {32'h00006666, 2'b01, 1'b1, 1'b1});
    chk("tail_cnt", err_cnt_o, 8'd2);

    // Backpressure: four halfwords fill both FIFO entries
    q.delete(); m_rdy_i = 1'b0;
    put(16'h0001, 1, 0); put(16'h0002, 0, 0); put(16'h0003, 0, 0); put(16'h0004, 0, 0);
    s_data_i = 16'h0005; s_sof = 1'b0; s_eof = 1'b0; s_vld_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", {63'h0, s_rdy_o}, 64'h0);
      chk("bp_head", {31'h0, m_vld_o, m_data_o}, {31'h0, 1'b1, 32'h00020001});
      cycles(1);
    end
    m_rdy_i = 1'b1;
    put(16'h0005, 0, 0); put(16'h0006, 0, 1);
    cycles(4);
    chk("bp_n", q.size(), 3);
    chk_word("bp_w0", 0, {32'h00020001, 2'b11, 1'b1, 1'b0});
    chk_word("bp_w1", 1, {32'h00040003, 2'b11, 1'b0, 1'b0});
    chk_word("bp_w2", 2, {32'h00060005, 2'b11, 1'b0, 1'b1});

    // Error counter saturation: 257 orphans
    q.delete(); err_pulses = 0;
    for (int i = 0; i < 258; i++)
      put(16'h1000 + 16'(i), 1, 0);
    put(16'h2000, 0, 1);
    cycles(2);
    chk("sat_pulses", err_pulses, 257);
    chk("sat_cnt", err_cnt_o, 8'hFF);

    // Reset mid-frame with one word buffered
    q.delete(); m_rdy_i = 1'b0;
    put(16'h00A1, 1, 0); put(16'h00A2, 0, 0); put(16'h7777, 1, 0);
    chk("pre_rst_vld", {63'h0, m_vld_o}, 64'h1);
    rst = 1'b1;
    cycles(1);
    chk("mid_rst_outs", {29'h0, m_vld_o, s_rdy_o, m_data_o, err_cnt_o != 8'h0}, 64'h0);
    rst = 1'b0; m_rdy_i = 1'b1;
    cycles(1);
    chk("post_rst_vld", {63'h0, m_vld_o}, 64'h0);
    chk("post_rst_cnt", err_cnt_o, 8'h0);
    put(16'h8888, 1, 0); put(16'h9999, 0, 1);
    cycles(3);
    chk("rst_n", q.size(), 1);
    chk_word("rst_w0", 0, {32'h99998888, 2'b11, 1'b1, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
